// File: rtl/axi_mem2p_pkg.sv
// Shared definitions for the axi_mem2p block: AXI response codes, port FSM
// encoding and width helpers.
package axi_mem2p_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_WR    = 3'd1;
  localparam logic [ST_W-1:0] ST_BRESP = 3'd2;
  localparam logic [ST_W-1:0] ST_RD    = 3'd3;
  localparam logic [ST_W-1:0] ST_RWAIT = 3'd4;
  localparam logic [ST_W-1:0] ST_RRESP = 3'd5;

  // Number of byte-offset bits below the word address.
  function automatic int unsigned byte_off_bits(input int unsigned dw);
    return (dw <= 8) ? 0 : $clog2(dw / 8);
  endfunction

  // Width of a down-counter holding values 0 .. n-1 (at least one bit).
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axil_mem_port_master.sv
// AXI4-Lite slave that turns single-beat reads/writes into native block-memory
// port cycles (en/we/addr/din/dout) on one port of a dual-port RAM.
module axil_mem_port_master
  import axi_mem2p_pkg::*;
#(
  parameter  int unsigned G_DATAWIDTH     = 32,
  parameter  int unsigned G_MEMDEPTH      = 1024,
  parameter  int unsigned G_AXI_ADDRWIDTH = 16,
  parameter  int unsigned G_RDLAT         = 1,
  localparam int unsigned G_WEWIDTH       = G_DATAWIDTH / 8,
  localparam int unsigned G_ADDRWIDTH     = $clog2(G_MEMDEPTH)
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [G_AXI_ADDRWIDTH-1:0] s_awaddr,
  input  logic                       s_awvalid,
  output logic                       s_awready,
  input  logic [G_DATAWIDTH-1:0]     s_wdata,
  input  logic [G_WEWIDTH-1:0]       s_wstrb,
  input  logic                       s_wvalid,
  output logic                       s_wready,
  output logic [1:0]                 s_bresp,
  output logic                       s_bvalid,
  input  logic                       s_bready,
  input  logic [G_AXI_ADDRWIDTH-1:0] s_araddr,
  input  logic                       s_arvalid,
  output logic                       s_arready,
  output logic [G_DATAWIDTH-1:0]     s_rdata,
  output logic [1:0]                 s_rresp,
  output logic                       s_rvalid,
  input  logic                       s_rready,
  output logic                       mem_en,
  output logic [G_WEWIDTH-1:0]       mem_we,
  output logic [G_ADDRWIDTH-1:0]     mem_addr,
  output logic [G_DATAWIDTH-1:0]     mem_din,
  input  logic [G_DATAWIDTH-1:0]     mem_dout
);

  localparam int unsigned OFFW = byte_off_bits(G_DATAWIDTH);
  localparam int unsigned CNTW = cnt_bits(G_RDLAT);

  // Word index must fall inside the array; any higher address bit set is out of range.
  function automatic logic addr_ok(input logic [G_AXI_ADDRWIDTH-1:0] a);
    return (a >> OFFW) < G_AXI_ADDRWIDTH'(G_MEMDEPTH);
  endfunction

  logic [ST_W-1:0]            state_q, state_n;
  logic                       aw_full_q, aw_full_n;
  logic [G_AXI_ADDRWIDTH-1:0] aw_addr_q, aw_addr_n;
  logic                       w_full_q, w_full_n;
  logic [G_DATAWIDTH-1:0]     w_data_q, w_data_n;
  logic [G_WEWIDTH-1:0]       w_strb_q, w_strb_n;
  logic                       rr_pri_q, rr_pri_n;   // 0: write wins, 1: read wins
  logic [CNTW-1:0]            cnt_q, cnt_n;
  logic                       rd_ok_q, rd_ok_n;

  logic                       awready_q, awready_n;
  logic                       wready_q, wready_n;
  logic                       arready_q, arready_n;
  logic                       bvalid_q, bvalid_n;
  logic [1:0]                 bresp_q, bresp_n;
  logic                       rvalid_q, rvalid_n;
  logic [1:0]                 rresp_q, rresp_n;
  logic [G_DATAWIDTH-1:0]     rdata_q, rdata_n;
  logic                       mem_en_q, mem_en_n;
  logic [G_WEWIDTH-1:0]       mem_we_q, mem_we_n;
  logic [G_ADDRWIDTH-1:0]     mem_addr_q, mem_addr_n;
  logic [G_DATAWIDTH-1:0]     mem_din_q, mem_din_n;

  logic aw_hs, w_hs, ar_hs, wr_rdy;

  assign aw_hs  = s_awvalid & awready_q;
  assign w_hs   = s_wvalid & wready_q;
  assign ar_hs  = s_arvalid & arready_q;
  assign wr_rdy = aw_full_q & w_full_q;

  // Next-state, holding registers, arbitration and next output values.
  always_comb begin
    state_n    = state_q;
    aw_full_n  = aw_full_q;
    aw_addr_n  = aw_addr_q;
    w_full_n   = w_full_q;
    w_data_n   = w_data_q;
    w_strb_n   = w_strb_q;
    rr_pri_n   = rr_pri_q;
    cnt_n      = cnt_q;
    rd_ok_n    = rd_ok_q;
    bvalid_n   = bvalid_q;
    bresp_n    = bresp_q;
    rvalid_n   = rvalid_q;
    rresp_n    = rresp_q;
    rdata_n    = rdata_q;
    mem_en_n   = 1'b0;
    mem_we_n   = '0;
    mem_addr_n = mem_addr_q;
    mem_din_n  = mem_din_q;

    if (aw_hs) begin
      aw_full_n = 1'b1;
      aw_addr_n = s_awaddr;
    end
    if (w_hs) begin
      w_full_n = 1'b1;
      w_data_n = s_wdata;
      w_strb_n = s_wstrb;
    end

    case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          state_n    = ST_RD;
          rd_ok_n    = addr_ok(s_araddr);
          mem_en_n   = addr_ok(s_araddr);
          mem_addr_n = s_araddr[OFFW +: G_ADDRWIDTH];
          if (wr_rdy) rr_pri_n = ~rr_pri_q;
        end else if (wr_rdy) begin
          state_n    = ST_WR;
          mem_en_n   = addr_ok(aw_addr_q);
          mem_we_n   = addr_ok(aw_addr_q) ? w_strb_q : '0;
          mem_addr_n = aw_addr_q[OFFW +: G_ADDRWIDTH];
          mem_din_n  = w_data_q;
          if (s_arvalid) rr_pri_n = ~rr_pri_q;
        end
      end
      ST_WR: begin
        state_n  = ST_BRESP;
        bvalid_n = 1'b1;
        bresp_n  = addr_ok(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
      end
      ST_BRESP: begin
        if (s_bready) begin
          state_n   = ST_IDLE;
          bvalid_n  = 1'b0;
          aw_full_n = 1'b0;
          w_full_n  = 1'b0;
        end
      end
      ST_RD: begin
        state_n = ST_RWAIT;
        cnt_n   = CNTW'(G_RDLAT - 1);
      end
      ST_RWAIT: begin
        if (cnt_q == '0) begin
          state_n  = ST_RRESP;
          rvalid_n = 1'b1;
          rdata_n  = rd_ok_q ? mem_dout : '0;
          rresp_n  = rd_ok_q ? RESP_OKAY : RESP_SLVERR;
        end else begin
          cnt_n = cnt_q - CNTW'(1);
        end
      end
      ST_RRESP: begin
        if (s_rready) begin
          state_n  = ST_IDLE;
          rvalid_n = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Readies are registered from next-cycle state, so they are low in reset.
    awready_n = (state_n == ST_IDLE) && !aw_full_n;
    wready_n  = (state_n == ST_IDLE) && !w_full_n;
    arready_n = (state_n == ST_IDLE) && !(aw_full_n && w_full_n && !rr_pri_n);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      aw_full_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      rr_pri_q   <= 1'b0;
      cnt_q      <= '0;
      rd_ok_q    <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= '0;
      rdata_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_n;
      aw_full_q  <= aw_full_n;
      aw_addr_q  <= aw_addr_n;
      w_full_q   <= w_full_n;
      w_data_q   <= w_data_n;
      w_strb_q   <= w_strb_n;
      rr_pri_q   <= rr_pri_n;
      cnt_q      <= cnt_n;
      rd_ok_q    <= rd_ok_n;
      awready_q  <= awready_n;
      wready_q   <= wready_n;
      arready_q  <= arready_n;
      bvalid_q   <= bvalid_n;
      bresp_q    <= bresp_n;
      rvalid_q   <= rvalid_n;
      rresp_q    <= rresp_n;
      rdata_q    <= rdata_n;
      mem_en_q   <= mem_en_n;
      mem_we_q   <= mem_we_n;
      mem_addr_q <= mem_addr_n;
      mem_din_q  <= mem_din_n;
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_arready = arready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_axil_mem_port_master.sv
// Bench for axil_mem_port_master: behavioural RAM on the memory port, a
// word-array reference model, directed cases and a randomized sequence.
module tb_axil_mem_port_master;

  localparam int unsigned DW     = 32;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned RDLAT  = 2;
  localparam int unsigned WEW    = DW / 8;
  localparam int unsigned MAW    = 10;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [ADDR_W-1:0] s_awaddr, s_araddr;
  logic              s_awvalid, s_awready, s_wvalid, s_wready;
  logic [DW-1:0]     s_wdata, s_rdata;
  logic [WEW-1:0]    s_wstrb;
  logic [1:0]        s_bresp, s_rresp;
  logic              s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic              mem_en;
  logic [WEW-1:0]    mem_we;
  logic [MAW-1:0]    mem_addr;
  logic [DW-1:0]     mem_din, mem_dout;

  always #5 aclk = ~aclk;

  axil_mem_port_master #(
    .G_DATAWIDTH(DW), .G_MEMDEPTH(DEPTH), .G_AXI_ADDRWIDTH(ADDR_W), .G_RDLAT(RDLAT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int unsigned i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Block RAM with RDLAT cycles from en to dout.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] rd1, rd2;
  logic          ram_init;
  always @(posedge aclk) begin
    if (ram_init) begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] <= init_word(32'(i));
    end else if (mem_en) begin
      for (int b = 0; b < int'(WEW); b++)
        if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
      rd1 <= ram[mem_addr];
    end
    rd2 <= rd1;
  end
  assign mem_dout = (RDLAT == 2) ? rd2 : rd1;

  // Memory-port monitor: pulse count, last access, and access kind log.
  int             cyc = 0;
  int             en_cnt = 0;
  logic [MAW-1:0] last_addr;
  logic [WEW-1:0] last_we;
  bit             kind_log [256];
  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      en_cnt    <= en_cnt + 1;
      last_addr <= mem_addr;
      last_we   <= mem_we;
      kind_log[en_cnt % 256] <= (mem_we != '0);
    end
  end

  // Reference model: array of words addressed by byte address / bytes-per-word.
  logic [DW-1:0] ref_mem [DEPTH];

  function automatic bit in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH * WEW;
  endfunction

  function automatic int unsigned widx(input logic [ADDR_W-1:0] a);
    return 32'(a) / WEW;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, 64'({s_awready, s_wready, s_bvalid, s_bresp, s_arready,
                              s_rvalid, s_rresp, mem_en, mem_we}), 64'h0);
    check({tag, "_rdata"}, 64'(s_rdata), 64'h0);
    check({tag, "_memaddr"}, 64'(mem_addr), 64'h0);
    check({tag, "_memdin"}, 64'(mem_din), 64'h0);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DW-1:0] d,
                          input logic [WEW-1:0] s, input int aw_dly, input int w_dly,
                          input int hold, input bit solo);
    int en0, hs_aw, hs_w, na, nw, nb;
    logic [1:0] exp_resp;
    en0 = en_cnt;
    hs_aw = 0;
    hs_w = 0;
    fork
      begin
        repeat (aw_dly) @(negedge aclk);
        s_awaddr = a; s_awvalid = 1'b1; na = 0;
        while (!s_awready && na < 100) begin @(negedge aclk); na++; end
        if (!s_awready) check("wr_aw_timeout", 64'(s_awready), 64'h1);
        hs_aw = cyc + 1;
        @(negedge aclk); s_awvalid = 1'b0;
      end
      begin
        repeat (w_dly) @(negedge aclk);
        s_wdata = d; s_wstrb = s; s_wvalid = 1'b1; nw = 0;
        while (!s_wready && nw < 100) begin @(negedge aclk); nw++; end
        if (!s_wready) check("wr_w_timeout", 64'(s_wready), 64'h1);
        hs_w = cyc + 1;
        @(negedge aclk); s_wvalid = 1'b0;
      end
    join
    s_bready = 1'b0; nb = 0;
    while (!s_bvalid && nb < 100) begin @(negedge aclk); nb++; end
    check("wr_bvalid", 64'(s_bvalid), 64'h1);
    if (solo) check("wr_latency", 64'(cyc - ((hs_aw > hs_w) ? hs_aw : hs_w)), 64'd2);
    exp_resp = in_range(a) ? 2'b00 : 2'b10;
    check("wr_bresp", 64'(s_bresp), 64'(exp_resp));
    if (in_range(a))
      for (int b = 0; b < int'(WEW); b++)
        if (s[b]) ref_mem[widx(a)][b*8 +: 8] = d[b*8 +: 8];
    for (int k = 0; k < hold; k++) begin
      @(negedge aclk);
      check("wr_hold_bvalid", 64'(s_bvalid), 64'h1);
      check("wr_hold_bresp", 64'(s_bresp), 64'(exp_resp));
      check("wr_hold_readys", 64'({s_awready, s_arready}), 64'h0);
    end
    s_bready = 1'b1;
    @(negedge aclk);
    s_bready = 1'b0;
    check("wr_bvalid_drop", 64'(s_bvalid), 64'h0);
    if (solo) begin
      check("wr_en_pulses", 64'(en_cnt - en0), in_range(a) ? 64'd1 : 64'd0);
      if (in_range(a)) begin
        check("wr_mem_addr", 64'(last_addr), 64'(widx(a)));
        check("wr_mem_we", 64'(last_we), 64'(s));
      end
    end
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input int hold, input bit solo,
                         output logic [DW-1:0] rd);
    int en0, hs, n;
    logic [DW-1:0] exp_data;
    logic [1:0] exp_resp;
    en0 = en_cnt;
    s_araddr = a; s_arvalid = 1'b1; n = 0;
    while (!s_arready && n < 100) begin @(negedge aclk); n++; end
    if (!s_arready) check("rd_ar_timeout", 64'(s_arready), 64'h1);
    hs = cyc + 1;
    @(negedge aclk); s_arvalid = 1'b0;
    s_rready = 1'b0; n = 0;
    while (!s_rvalid && n < 100) begin @(negedge aclk); n++; end
    check("rd_rvalid", 64'(s_rvalid), 64'h1);
    if (solo) check("rd_latency", 64'(cyc - hs), 64'(1 + RDLAT));
    exp_data = in_range(a) ? ref_mem[widx(a)] : '0;
    exp_resp = in_range(a) ? 2'b00 : 2'b10;
    check("rd_rdata", 64'(s_rdata), 64'(exp_data));
    check("rd_rresp", 64'(s_rresp), 64'(exp_resp));
    rd = s_rdata;
    for (int k = 0; k < hold; k++) begin
      @(negedge aclk);
      check("rd_hold_rvalid", 64'(s_rvalid), 64'h1);
      check("rd_hold_rdata", 64'(s_rdata), 64'(exp_data));
      check("rd_hold_readys", 64'({s_awready, s_arready}), 64'h0);
    end
    s_rready = 1'b1;
    @(negedge aclk);
    s_rready = 1'b0;
    check("rd_rvalid_drop", 64'(s_rvalid), 64'h0);
    if (solo) check("rd_en_pulses", 64'(en_cnt - en0), in_range(a) ? 64'd1 : 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    logic [ADDR_W-1:0] a;
    int idx0, n;

    aresetn = 1'b0; ram_init = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(32'(i));

    @(negedge aclk);
    check_outputs_zero("reset");
    repeat (2) @(negedge aclk);
    ram_init = 1'b0;
    aresetn = 1'b1;
    @(negedge aclk);

    // Basic full-word write then read back.
    do_write(16'h0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 1'b1);
    check("basic_mem_addr", 64'(last_addr), 64'd4);
    do_read(16'h0010, 0, 1'b1, rd);
    check("basic_rdata", 64'(rd), 64'hDEAD_BEEF);

    // W three cycles ahead of AW, single byte lane merge.
    do_write(16'h0020, 32'h1122_3344, 4'hF, 0, 0, 0, 1'b1);
    do_write(16'h0020, 32'h0000_AB00, 4'h2, 3, 0, 0, 1'b1);
    do_read(16'h0020, 0, 1'b1, rd);
    check("partial_rdata", 64'(rd), 64'h1122_AB44);

    // Zero strobe: no data change, OKAY.
    do_write(16'h0024, 32'hFFFF_FFFF, 4'h0, 0, 2, 0, 1'b1);
    do_read(16'h0024, 0, 1'b1, rd);

    // Out-of-range accesses.
    do_read(16'h1000, 0, 1'b1, rd);
    do_write(16'h1000, 32'h1234_5678, 4'hF, 0, 0, 0, 1'b1);
    do_read(16'hFFFC, 0, 1'b1, rd);

    // Write-ready and arvalid together: first write wins, then read wins.
    idx0 = en_cnt;
    fork
      do_write(16'h0040, 32'hCAFE_0001, 4'hF, 0, 0, 0, 1'b0);
      begin @(negedge aclk); do_read(16'h0080, 0, 1'b0, rd); end
    join
    check("arb1_first_is_write", 64'(kind_log[idx0 % 256]), 64'h1);
    check("arb1_second_is_read", 64'(kind_log[(idx0 + 1) % 256]), 64'h0);
    idx0 = en_cnt;
    fork
      do_write(16'h0044, 32'hCAFE_0002, 4'hF, 0, 0, 0, 1'b0);
      begin @(negedge aclk); do_read(16'h0084, 0, 1'b0, rd); end
    join
    check("arb2_first_is_read", 64'(kind_log[idx0 % 256]), 64'h0);
    check("arb2_second_is_write", 64'(kind_log[(idx0 + 1) % 256]), 64'h1);
    do_read(16'h0040, 0, 1'b1, rd);
    do_read(16'h0044, 0, 1'b1, rd);

    // Backpressure on both response channels.
    do_write(16'h0100, 32'h0BAD_F00D, 4'hF, 0, 0, 5, 1'b1);
    do_read(16'h0100, 5, 1'b1, rd);

    // Reset while the read waits for memory data.
    s_araddr = 16'h0100; s_arvalid = 1'b1; n = 0;
    while (!s_arready && n < 100) begin @(negedge aclk); n++; end
    @(negedge aclk); s_arvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check_outputs_zero("midreset");
    s_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      check("midreset_rvalid", 64'(s_rvalid), 64'h0);
    end
    s_rready = 1'b0;
    aresetn = 1'b1;
    @(negedge aclk);
    check("postreset_rvalid", 64'(s_rvalid), 64'h0);
    do_read(16'h0100, 0, 1'b1, rd);

    // Randomized sequential traffic against the reference model.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 9) == 0) a = ADDR_W'($urandom_range(32'h1000, 32'hFFFF));
      else a = ADDR_W'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, WEW'($urandom_range(0, 15)), $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
      else
        do_read(a, $urandom_range(0, 2), 1'b1, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
